// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3 message loader: lane width, FSM state types
// and the tail-lane byte mask helper.
package sha3_pkg;

   localparam int LANE_W = 64;

   typedef enum logic [1:0] {
      F_IDLE,
      F_REQ,
      F_WAIT
   } fetch_state_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LANE,
      S_PAD,
      S_DRAIN,
      S_DONE
   } stream_state_t;

   // Keeps the low 'tail' bytes of a lane, clears the rest.
   function automatic logic [LANE_W-1:0] lane_mask(input logic [2:0] tail);
      logic [LANE_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < 32'(LANE_W / 8); b++) begin
         if (b < 32'(tail)) m[b*8 +: 8] = '1;
      end
      return m;
   endfunction

endpackage

// File: rtl/sha3_beat_fifo.sv
// Synchronous W x DEPTH beat FIFO with full/empty flags and free-entry count.
// A push while full is dropped; read data is the current head entry.
module sha3_beat_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_free
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_free    = (AW+1)'(DEPTH) - r_count;
   assign o_rdata   = r_mem[r_rd];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= r_rd + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sha3_msg_loader.sv
// Fetches a message in bursts, splits bus beats into 64-bit lanes and streams
// them to the Keccak core. SHA3_LOADER_PERF_EN adds the perf_cycles counter.
module sha3_msg_loader
   import sha3_pkg::*;
#(
   parameter int BUS_W           = 128,
   parameter int BEATS_PER_BURST = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter int LEN_W           = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  msg_len,
   output logic              busy,
   output logic              done,
   output logic              overflow,
`ifdef SHA3_LOADER_PERF_EN
   output logic [31:0]       perf_cycles,
`endif
   output logic              init_master_txn,
   output logic [31:0]       read_addr_index,
   input  logic              read_done,
   input  logic              bus_data_valid,
   input  logic [BUS_W-1:0]  ocm_data_out,
   output logic              bus_read_ready,
   output logic [63:0]       keccak_input,
   output logic              in_ready,
   output logic              is_last,
   output logic [2:0]        byte_num,
   input  logic              buffer_full
);

   localparam int LPB         = BUS_W / LANE_W;
   localparam int SEL_W       = (LPB > 1) ? $clog2(LPB) : 1;
   localparam int BURST_BYTES = BEATS_PER_BURST * BUS_W / 8;
   localparam int FCNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W       = LEN_W - 2;

   fetch_state_t      r_fstate, w_fnext;
   stream_state_t     r_sstate, w_snext;

   logic [LEN_W-1:0]  r_bursts_left;
   logic [31:0]       r_addr_idx;
   logic [CNT_W-1:0]  r_lanes_left;
   logic [2:0]        r_tail;
   logic [BUS_W-1:0]  r_beat;
   logic              r_beat_valid;
   logic [SEL_W-1:0]  r_lane_sel;
   logic              r_overflow;

   logic              w_busy;
   logic              w_accept;
   logic [LEN_W-1:0]  w_bursts;
   logic [CNT_W-1:0]  w_lanes;
   logic [BUS_W-1:0]  w_fifo_rdata;
   logic              w_full;
   logic              w_empty;
   logic [FCNT_W-1:0] w_free;
   logic              w_push;
   logic              w_pop;
   logic [LANE_W-1:0] w_lane;
   logic              w_final;
   logic              w_lane_last_in_beat;
   logic              w_lane_consume;
   logic              w_drain;
   logic              w_beat_free;

   // Ceiling divisions done in 32 bits so msg_len at its maximum cannot wrap.
   assign w_bursts = LEN_W'(32'(msg_len) / 32'(BURST_BYTES))
                   + LEN_W'(32'(msg_len) % 32'(BURST_BYTES) != 32'd0);
   assign w_lanes  = CNT_W'((32'(msg_len) + 32'd7) >> 3);

   assign w_busy          = (r_sstate != S_IDLE) && (r_sstate != S_DONE);
   assign w_accept        = start && !w_busy;
   assign busy            = w_busy;
   assign overflow        = r_overflow;
   assign read_addr_index = r_addr_idx;
   assign bus_read_ready  = w_busy && (w_free >= FCNT_W'(BEATS_PER_BURST));

   assign w_push = w_busy && bus_data_valid;

   sha3_beat_fifo #(
      .W     (BUS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_wdata (ocm_data_out),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_free  (w_free)
   );

   always_comb begin
      w_fnext         = r_fstate;
      init_master_txn = 1'b0;
      case (r_fstate)
         F_IDLE: if (w_accept && (w_bursts != '0)) w_fnext = F_REQ;
         F_REQ: begin
            if (bus_read_ready) begin
               init_master_txn = 1'b1;
               w_fnext         = F_WAIT;
            end
         end
         F_WAIT: begin
            if (read_done) w_fnext = (r_bursts_left > LEN_W'(1)) ? F_REQ : F_IDLE;
         end
         default: w_fnext = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fstate      <= F_IDLE;
         r_addr_idx    <= '0;
         r_bursts_left <= '0;
      end else begin
         r_fstate <= w_fnext;
         if (w_accept) begin
            r_addr_idx    <= '0;
            r_bursts_left <= w_bursts;
         end else if ((r_fstate == F_WAIT) && read_done) begin
            r_addr_idx    <= r_addr_idx + 32'd1;
            r_bursts_left <= r_bursts_left - LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         r_overflow <= 1'b0;
      else if (w_push && w_full)            r_overflow <= 1'b1;
   end

   assign w_lane              = r_beat[r_lane_sel*LANE_W +: LANE_W];
   assign w_final             = (r_lanes_left == CNT_W'(1));
   assign w_lane_last_in_beat = (r_lane_sel == SEL_W'(LPB - 1));
   assign w_lane_consume      = (r_sstate == S_LANE) && r_beat_valid && !buffer_full;
   assign w_drain             = (r_sstate == S_DRAIN) && r_beat_valid;
   // Draining discards a whole beat per cycle; any unused lanes are irrelevant.
   assign w_beat_free         = !r_beat_valid || w_drain
                              || (w_lane_consume && w_lane_last_in_beat);
   assign w_pop               = w_busy && !w_empty && w_beat_free;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat       <= '0;
         r_beat_valid <= 1'b0;
         r_lane_sel   <= '0;
      end else if (w_pop) begin
         r_beat       <= w_fifo_rdata;
         r_beat_valid <= 1'b1;
         r_lane_sel   <= '0;
      end else if (r_beat_valid && w_beat_free) begin
         r_beat_valid <= 1'b0;
      end else if (w_lane_consume) begin
         r_lane_sel   <= r_lane_sel + SEL_W'(1);
      end
   end

   always_comb begin
      w_snext      = r_sstate;
      in_ready     = 1'b0;
      keccak_input = '0;
      is_last      = 1'b0;
      byte_num     = '0;
      done         = 1'b0;
      case (r_sstate)
         S_IDLE, S_DONE: begin
            done = (r_sstate == S_DONE);
            if (w_accept)               w_snext = (msg_len == '0) ? S_PAD : S_LANE;
            else if (r_sstate == S_DONE) w_snext = S_IDLE;
         end
         S_LANE: begin
            if (r_beat_valid) begin
               in_ready     = 1'b1;
               is_last      = w_final && (r_tail != 3'd0);
               byte_num     = is_last ? r_tail : 3'd0;
               keccak_input = is_last ? (w_lane & lane_mask(r_tail)) : w_lane;
            end
            if (w_lane_consume && w_final) w_snext = (r_tail == 3'd0) ? S_PAD : S_DRAIN;
         end
         S_PAD: begin
            in_ready = 1'b1;
            is_last  = 1'b1;
            if (!buffer_full) w_snext = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_fstate == F_IDLE) && w_empty && !r_beat_valid) w_snext = S_DONE;
         end
         default: w_snext = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sstate     <= S_IDLE;
         r_lanes_left <= '0;
         r_tail       <= '0;
      end else begin
         r_sstate <= w_snext;
         if (w_accept) begin
            r_lanes_left <= w_lanes;
            r_tail       <= msg_len[2:0];
         end else if (w_lane_consume) begin
            r_lanes_left <= r_lanes_left - CNT_W'(1);
         end
      end
   end

`ifdef SHA3_LOADER_PERF_EN
   logic [31:0] r_perf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_perf <= '0;
      else if (w_accept) r_perf <= '0;
      else if (w_busy)   r_perf <= r_perf + 32'd1;
   end

   assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_sha3_msg_loader.sv
// Directed bench for sha3_msg_loader: a burst responder feeds beats whose byte k
// of the message equals k[7:0]; every transferred Keccak word is checked.
module tb_sha3_msg_loader;

   localparam int BUS_W      = 128;
   localparam int BPB        = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int LEN_W      = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [LEN_W-1:0]  msg_len;
   logic              busy, done, overflow, init_master_txn;
   logic [31:0]       read_addr_index;
   logic              read_done = 1'b0;
   logic              bus_data_valid;
   logic [BUS_W-1:0]  ocm_data_out;
   logic              bus_read_ready;
   logic [63:0]       keccak_input;
   logic              in_ready, is_last;
   logic [2:0]        byte_num;
   logic              buffer_full;
`ifdef SHA3_LOADER_PERF_EN
   logic [31:0]       perf_cycles;
`endif

   logic              rsp_valid = 1'b0;
   logic [BUS_W-1:0]  rsp_data  = '0;
   logic              inj_valid;
   logic [BUS_W-1:0]  inj_data;
   bit                bus_auto;
   int                rsp_left = 0;
   int                rsp_beat = 0;
   int                n_txn    = 0;
   int                checks   = 0;
   int                errors   = 0;

   assign bus_data_valid = rsp_valid | inj_valid;
   assign ocm_data_out   = inj_valid ? inj_data : rsp_data;

   always #5 clk = ~clk;

   sha3_msg_loader #(
      .BUS_W           (BUS_W),
      .BEATS_PER_BURST (BPB),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .LEN_W           (LEN_W)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .msg_len         (msg_len),
      .busy            (busy),
      .done            (done),
      .overflow        (overflow),
`ifdef SHA3_LOADER_PERF_EN
      .perf_cycles     (perf_cycles),
`endif
      .init_master_txn (init_master_txn),
      .read_addr_index (read_addr_index),
      .read_done       (read_done),
      .bus_data_valid  (bus_data_valid),
      .ocm_data_out    (ocm_data_out),
      .bus_read_ready  (bus_read_ready),
      .keccak_input    (keccak_input),
      .in_ready        (in_ready),
      .is_last         (is_last),
      .byte_num        (byte_num),
      .buffer_full     (buffer_full)
   );

   function automatic logic [BUS_W-1:0] beat_of(input int g);
      logic [BUS_W-1:0] b;
      for (int p = 0; p < BUS_W/8; p++) b[p*8 +: 8] = 8'((g*(BUS_W/8) + p) & 255);
      return b;
   endfunction

   function automatic logic [63:0] exp_lane(input int i, input int len);
      logic [63:0] l;
      l = '0;
      for (int b = 0; b < 8; b++) if (8*i + b < len) l[b*8 +: 8] = 8'((8*i + b) & 255);
      return l;
   endfunction

   // Burst responder: BPB beats after each request, read_done with the last beat.
   always @(negedge clk) begin
      rsp_valid = 1'b0;
      read_done = 1'b0;
      if (!reset_n) begin
         rsp_left = 0;
      end else if (rsp_left > 0) begin
         rsp_valid = 1'b1;
         rsp_data  = beat_of(rsp_beat);
         rsp_beat++;
         rsp_left--;
         read_done = (rsp_left == 0);
      end else if (init_master_txn && bus_auto) begin
         rsp_left = BPB;
         rsp_beat = int'(read_addr_index) * BPB;
         n_txn++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_word(input string tag, input int i, input int len);
      int          lanes = (len + 7) / 8;
      int          tail  = len % 8;
      logic [63:0] ed;
      logic        el;
      logic [2:0]  eb;
      ed = (i < lanes) ? exp_lane(i, len) : 64'd0;
      el = ((i == lanes - 1) && (tail != 0)) || ((i == lanes) && (tail == 0));
      eb = ((i == lanes - 1) && (tail != 0)) ? 3'(tail) : 3'd0;
      chk($sformatf("%s w%0d data", tag, i), keccak_input, ed);
      chk($sformatf("%s w%0d is_last", tag, i), is_last, el);
      chk($sformatf("%s w%0d byte_num", tag, i), byte_num, eb);
   endtask

   task automatic run_msg(input string tag, input int len, input int stall_at,
                          input int exp_bursts, output logic [63:0] word1);
      int           exp_words = (len + 7) / 8 + (((len % 8) == 0) ? 1 : 0);
      int           nw = 0, cyc = 0, stall_left = 0, txn0;
      bit           stalled = 0, got_done = 0;
      logic [127:0] snap = '0;
      word1 = '0;
      txn0  = n_txn;
      @(negedge clk);
      msg_len = LEN_W'(len);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy after start"}, busy, 1'b1);
      chk({tag, " first init"}, init_master_txn, (len != 0));
      while (!got_done && cyc < 3000) begin
         buffer_full = 1'b0;
         if (stall_left > 0) begin
            buffer_full = 1'b1;
            stall_left--;
            chk({tag, " stall hold"}, {in_ready, is_last, byte_num, keccak_input}, snap);
         end else if (!stalled && stall_at >= 0 && nw == stall_at && in_ready) begin
            stalled     = 1;
            stall_left  = 9;
            buffer_full = 1'b1;
            snap        = {59'd0, in_ready, is_last, byte_num, keccak_input};
         end
         if (in_ready && !buffer_full) begin
            check_word(tag, nw, len);
            if (nw == 1) word1 = keccak_input;
            nw++;
         end
         if (done) begin
            got_done = 1;
            chk({tag, " busy at done"}, busy, 1'b0);
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      buffer_full = 1'b0;
      chk({tag, " done seen"}, got_done, 1'b1);
      chk({tag, " words"}, nw, exp_words);
      chk({tag, " bursts"}, n_txn - txn0, exp_bursts);
      chk({tag, " addr index"}, read_addr_index, exp_bursts);
      @(negedge clk);
      chk({tag, " done one pulse"}, done, 1'b0);
   endtask

   initial begin
      logic [63:0] w1;
      reset_n     = 1'b1;
      start       = 1'b0;
      msg_len     = '0;
      buffer_full = 1'b0;
      inj_valid   = 1'b0;
      inj_data    = '0;
      bus_auto    = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      chk("reset ctrl", {busy, done, overflow, init_master_txn, bus_read_ready,
                         in_ready, is_last, byte_num}, '0);
      chk("reset addr", read_addr_index, '0);
      chk("reset data", keccak_input, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle ready", bus_read_ready, 1'b0);

      run_msg("len64", 64, -1, 1, w1);
      chk("len64 lane1", w1, 64'h0F0E0D0C0B0A0908);

      run_msg("len13", 13, -1, 1, w1);
      chk("len13 lane1", w1, 64'h0000000C0B0A0908);

      run_msg("len200", 200, 5, 4, w1);
      run_msg("len0", 0, -1, 0, w1);

      // Overflow: no bursts served, Keccak stalled, beats injected directly.
      bus_auto    = 1'b0;
      buffer_full = 1'b1;
      @(negedge clk);
      chk("ovf clear before", overflow, 1'b0);
      msg_len = LEN_W'(200);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         inj_valid = 1'b1;
         inj_data  = beat_of(i);
         @(negedge clk);
      end
      inj_valid = 1'b0;
      @(negedge clk);
      chk("ovf set", overflow, 1'b1);
      repeat (5) @(negedge clk);
      chk("ovf sticky", overflow, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("ovf reset", overflow, 1'b0);
      @(negedge clk);
      reset_n     = 1'b1;
      buffer_full = 1'b0;
      bus_auto    = 1'b1;

      // Reset mid-burst, then a fresh message.
      @(negedge clk);
      msg_len = LEN_W'(200);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40 && !rsp_valid; c++) begin
         @(negedge clk);
         #1;
      end
      chk("midburst beats", rsp_valid, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("midreset ctrl", {busy, done, overflow, init_master_txn, bus_read_ready,
                            in_ready, is_last, byte_num}, '0);
      chk("midreset addr", read_addr_index, '0);
      chk("midreset data", keccak_input, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      run_msg("len16", 16, -1, 1, w1);
      chk("len16 lane1", w1, 64'h0F0E0D0C0B0A0908);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha3_msg_loader.md
# sha3_msg_loader

Parametrised message loader between the burst read master and the Keccak core. On `start` it fetches a runtime-length message in bursts, buffers the bus beats, and splits each beat into 64-bit lanes. It streams the lanes into the Keccak input port with backpressure, and generates `is_last`/`byte_num` from the byte length. Ports are named to connect directly to the SHA3 burst master.

## Interface
- `BUS_W`, 128: bus beat width; must be a multiple of 64.
- `BEATS_PER_BURST`, 4: beats returned per `init_master_txn`.
- `FIFO_DEPTH`, 8: beat FIFO depth; power of two and ≥ `BEATS_PER_BURST`.
- `LEN_W`, 16: width of the message length.

Ports (one clock `clk`; `reset_n` is asynchronous, active-low):
- `clk`  in  1  clock
- `reset_n`  in  1  async active-low reset
- `start`  in  1  one-cycle request; ignored while `busy`
- `msg_len`  in  `LEN_W`  message length in bytes, sampled with `start`
- `busy`  out  1  high from accepted `start` to `done`
- `done`  out  1  one-cycle pulse at completion
- `overflow`  out  1  sticky; a beat arrived while the FIFO was full
- `init_master_txn`  out  1  one-cycle burst request pulse
- `read_addr_index`  out  32  burst index of the current/next burst
- `read_done`  in  1  burst complete
- `bus_data_valid`  in  1  beat valid
- `ocm_data_out`  in  `BUS_W`  beat data
- `bus_read_ready`  out  1  FIFO free entries ≥ `BEATS_PER_BURST`
- `keccak_input`  out  64  lane to Keccak
- `in_ready`  out  1  lane valid
- `is_last`  out  1  final word of message
- `byte_num`  out  3  valid bytes in final word
- `buffer_full`  in  1  Keccak backpressure

## Operation
- Derived values at `start`:
  - `lanes = ceil(msg_len/8)`.
  - `bursts = ceil(msg_len/(BEATS_PER_BURST*BUS_W/8))`.
  - `tail = msg_len[2:0]`.
- Fetch FSM: `F_IDLE → F_REQ → F_WAIT → F_REQ … → F_IDLE`.
  - `F_REQ` pulses `init_master_txn` only while `bus_read_ready`; otherwise it waits.
  - `F_WAIT` increments `read_addr_index` on `read_done`. It returns to `F_REQ` if bursts remain, else to `F_IDLE`.
  - `read_addr_index` clears to 0 on each accepted `start`.
- Beat FIFO: `bus_data_valid` pushes the beat.
  - A push into a full FIFO is dropped and sets `overflow` until reset.
- Unpacker: pops a beat and emits `BUS_W/64` lanes, bits [63:0] first.
- Stream FSM: `S_IDLE → S_LANE → (S_PAD) → S_DRAIN → S_DONE → S_IDLE`.
  - `S_LANE` presents lanes.
    - The final lane has `is_last=1` and `byte_num=tail` when `tail≠0`.
    - Bytes beyond `msg_len` in that lane are driven as zero.
  - `S_PAD` is entered only when `tail==0`. It presents a single word with `is_last=1`, `byte_num=0`, data 0.
  - `msg_len==0`: zero bursts; the FSM goes directly to `S_PAD`.
  - `S_DRAIN` discards fetched lanes past `lanes` until the fetch FSM is idle and the FIFO is empty.
  - `S_DONE` pulses `done` and drops `busy`.
- Arithmetic: lane counters are `LEN_W-2` bits. `bursts` uses ceiling division with no overflow at `msg_len` max.

## Timing
- Reset values: all outputs 0; `keccak_input` 0; both FSMs idle; FIFO empty.
- `reset_n` low mid-operation aborts immediately. In-flight beats after release are ignored, because not `busy` blocks pushes.
- `start` sampled at edge N gives `busy=1` at N+1. The first `init_master_txn` is at N+1 if `bus_read_ready`.
- Lane transfer: a lane moves on an edge where `in_ready && !buffer_full`.
  - While `buffer_full` is high, `in_ready`, data, `is_last` and `byte_num` hold stable.
  - The next lane may be presented the cycle after a transfer, giving 1 lane/cycle sustained.
- FIFO-to-lane latency: 1 cycle (registered pop).
- `read_done` and `bus_data_valid` arriving in the same cycle are both honoured.
- `done` occurs 1 cycle after the final transfer, or later if draining is still required.

## Configuration
- `SHA3_LOADER_PERF_EN` defined: adds output `perf_cycles` [31:0].
  - Cleared at accepted `start`; increments each `busy` cycle; holds after `done`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `sha3_pkg`: lane width constant (64) and the fetch/stream state enums.
- One sub-module, `sha3_beat_fifo`: synchronous `BUS_W`×`FIFO_DEPTH` FIFO with full/empty/free-count.

## Test plan
- `msg_len=64`, `BUS_W=128`, `BEATS_PER_BURST=4`, `buffer_full=0`:
  - 1 burst; 8 lanes transferred.
  - Lane 7 has `is_last=0`; a 9th pad word follows with `is_last=1`, `byte_num=0`.
  - Then `done`.
- `msg_len=13`: 1 burst; lane 1 has `is_last=1`, `byte_num=5`, upper 3 bytes zero; the remaining 6 lanes are drained; `done`.
- `msg_len=200`:
  - 4 bursts, `read_addr_index` 0→4.
  - Last lane `byte_num=0`, followed by a pad word.
  - Hold `buffer_full=1` for 10 cycles mid-stream: outputs are stable and no lane is lost or duplicated.
- `msg_len=0`: no `init_master_txn`; a single pad word, then `done`.
- Inject `bus_data_valid` with the FIFO full: `overflow=1` persists until `reset_n` low.
- Reset asserted mid-burst: all outputs are 0 asynchronously. A subsequent `start` with `msg_len=16` completes correctly.
